elixirchip_es1_spu_op_shift: RTL and testbench
==============================================

# elixirchip_es1_spu_op_shift

Parametrised multi-mode shift unit for the ES1 SPU datapath, generalising the single-mode arithmetic right shifter. It performs SLL/SRL/SRA/ROL/ROR selected per beat, with saturating shift amounts up to MAX_SHIFT. It produces shifted-out carry and valid outputs through a clock-enabled pipeline of configurable latency, and keeps clear/hold semantics compatible with the other spu_op blocks.

## Interface
- LATENCY, 2: pipeline registers from input to output; legal range 1..4.
- DATA_BITS, 32: operand width; legal range 2..64.
- data_t, logic [DATA_BITS-1:0]: data type.
- MAX_SHIFT, DATA_BITS: largest shift amount the unit must honour; legal range 1..2*DATA_BITS.
- SHIFT_BITS, $clog2(MAX_SHIFT+1): width of s_shift.
- CLEAR_DATA, '0: value loaded on clear.
- IMMEDIATE_SHIFT, 1'b0: 1 when s_shift is constant; lets synthesis fold logic, with identical behaviour.
- IMMEDIATE_OP, 1'b0: 1 when s_op is constant; lets synthesis fold logic, with identical behaviour.
- DEVICE, "RTL": target device string.
- SIMULATION, "false": simulation-only checks.
- DEBUG, "false": debug attributes.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- cke  in  1  clock enable; 0 freezes every register.
- s_op  in  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; codes 5..7 are reserved.
- s_shift  in  SHIFT_BITS  shift amount, unsigned.
- s_data  in  DATA_BITS  operand.
- s_clear  in  1  load CLEAR_DATA.
- s_valid  in  1  input beat valid.
- m_data  out  DATA_BITS  result.
- m_carry  out  1  last bit shifted or rotated out.
- m_valid  out  1  output valid.

## Operation
- The result is computed combinationally in stage 0 and registered into stage 1.
- Stage 1 update rule, applied only when cke=1:
  - s_clear=1: data<=CLEAR_DATA, carry<=0, valid<=s_valid. Clear has priority over s_valid.
  - else s_valid=1: data and carry take the new result, valid<=1.
  - else: data and carry hold, valid<=0.
- Stages 2..LATENCY copy the previous stage when cke=1.
- Shift semantics for amount n (zero-extended), with W = DATA_BITS:
  - SLL, n<W: data<<n, carry=s_data[W-n]. n≥W: data 0, carry=s_data[0] if n==W else 0.
  - SRL, n<W: data>>n, carry=s_data[n-1]. n≥W: data 0, carry=s_data[W-1] if n==W else 0.
  - SRA, n<W: sign-filled shift, carry=s_data[n-1]. n≥W: data all sign bits, carry=sign.
  - ROL/ROR: rotate by n mod W. Carry is result[0] for ROL and result[W-1] for ROR.
  - n==0 for any op: data unchanged, carry 0.
- Reserved s_op codes give data=CLEAR_DATA and carry=0. With SIMULATION="true" they also raise an $error.
- s_shift values above MAX_SHIFT are outside the contract. With SIMULATION="true" they raise an $error; the RTL still applies the saturation rules above.

## Timing
- Reset (reset_n=0, asynchronous): all stages load data=CLEAR_DATA, carry=0, valid=0.
  - m_data=CLEAR_DATA, m_carry=0 and m_valid=0 immediately, independent of clk.
  - Release is synchronous to the clk edge. The first update occurs on the first rising edge with reset_n=1 and cke=1.
- Latency: exactly LATENCY enabled cycles (cycles with cke=1) from input to m_*.
- cke=0 cycles are invisible: no stage changes and outputs hold.
- Throughput: one beat per enabled cycle; there is no backpressure.
- Reset asserted mid-stream discards all in-flight beats. No partial outputs appear after release.

## Configuration
- ELIXIRCHIP_ES1_SPU_OP_SHIFT_ROTATE_EN defined: ROL and ROR are implemented as specified.
- Macro undefined: rotate logic is not built.
  - Codes 3 and 4 behave as reserved codes (CLEAR_DATA, carry 0, $error in simulation).
  - The barrel-shifter area shrinks.

## Structure
- Package elixirchip_es1_spu_pkg holds:
  - enum shift_op_t with values SHIFT_SLL..SHIFT_ROR;
  - localparam SHIFT_OP_BITS = 3.
- Sub-module elixirchip_es1_spu_op_shift_core: purely combinational, taking (op, shift, data) and producing (data, carry).
- The top level owns the clear/valid/cke pipeline, sized by LATENCY with a generate loop.

## Test plan
All scenarios use DATA_BITS=32, MAX_SHIFT=32, LATENCY=3, CLEAR_DATA=123 and the macro defined.
- SRA, s_data 0x87654321, n=8 -> m_data 0xff876543, m_carry 0, m_valid 1 on the 3rd enabled cycle.
- SRL with the same input, then SLL 0x12345678 n=4 -> 0x00876543 carry 0, then 0x23456780 carry 1 (back-to-back beats).
- ROR 0x12345678 n=8 -> 0x78123456 carry 0. ROL n=36 is out of contract (must report $error); the data result is the same as n=4: 0x23456781.
- SRA 0x87654321 n=32 -> 0xffffffff carry 1. SLL n=0 -> input unchanged, carry 0.
- Sequence: cke=0 for 2 cycles mid-stream, then s_clear=1 with s_valid=1, then s_valid=0.
  - Outputs freeze during cke=0, with no beat lost.
  - Then m_data=123, m_valid=1.
  - Then m_data holds 123 with m_valid=0.
- reset_n pulsed low between clock edges with 3 beats in flight.
  - Outputs go to 123/0/0 immediately.
  - No stale beat appears after release.
  - s_op=6 asserts $error and gives m_data 123.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_shift_pkg.sv
// Shared definitions for the ES1 SPU shift unit: operation encoding and its width.
package elixirchip_es1_spu_pkg;

  localparam int SHIFT_OP_BITS = 3;

  typedef enum logic [SHIFT_OP_BITS-1:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_t;

endpackage

// File: rtl/elixirchip_es1_spu_op_shift_if.sv
// Beat bus of the ES1 SPU shift unit: s_* request side, m_* result side.
interface elixirchip_es1_spu_op_shift_if
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int SHIFT_BITS = 6
);
  logic [SHIFT_OP_BITS-1:0] s_op;
  logic [SHIFT_BITS-1:0]    s_shift;
  logic [DATA_BITS-1:0]     s_data;
  logic                     s_clear;
  logic                     s_valid;
  logic [DATA_BITS-1:0]     m_data;
  logic                     m_carry;
  logic                     m_valid;

  modport master (
    output s_op, s_shift, s_data, s_clear, s_valid,
    input  m_data, m_carry, m_valid
  );

  modport slave (
    input  s_op, s_shift, s_data, s_clear, s_valid,
    output m_data, m_carry, m_valid
  );
endinterface

// File: rtl/elixirchip_es1_spu_op_shift_core.sv
// Combinational shift/rotate core of the ES1 SPU shift unit.
// Rotate support is built only when ELIXIRCHIP_ES1_SPU_OP_SHIFT_ROTATE_EN is defined;
// otherwise ROL/ROR decode like reserved codes.
module elixirchip_es1_spu_op_shift_core
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int                   DATA_BITS  = 32,
  parameter int                   SHIFT_BITS = 6,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0
) (
  input  logic [SHIFT_OP_BITS-1:0] i_op,
  input  logic [SHIFT_BITS-1:0]    i_shift,
  input  logic [DATA_BITS-1:0]     i_data,
  output logic [DATA_BITS-1:0]     o_data,
  output logic                     o_carry
);
  localparam int W = DATA_BITS;

  logic [31:0]         w_n;
  logic [W:0]          w_sll;
  logic [W:0]          w_srl;
  logic signed [W:0]   w_sra;

  assign w_n = 32'(i_shift);

  // One guard bit on the shifted-out side carries the last bit lost; a zero guard
  // makes n==0 report carry 0 for free.
  assign w_sll = {1'b0, i_data} << w_n;
  assign w_srl = {i_data, 1'b0} >> w_n;
  // Arithmetic shift saturates naturally: any n>=W leaves every bit (guard included) = sign.
  assign w_sra = $signed({i_data, 1'b0}) >>> w_n;

`ifdef ELIXIRCHIP_ES1_SPU_OP_SHIFT_ROTATE_EN
  logic [31:0]  w_m;
  logic [W-1:0] w_rol;
  logic [W-1:0] w_ror;

  assign w_m   = w_n % 32'(W);
  // With w_m==0 the complementary shift is by W and contributes nothing.
  assign w_rol = (i_data << w_m) | (i_data >> (32'(W) - w_m));
  assign w_ror = (i_data >> w_m) | (i_data << (32'(W) - w_m));
`endif

  // Select the result for the requested operation; n>W zeroes logical shifts.
  always_comb begin
    o_data  = CLEAR_DATA;
    o_carry = 1'b0;
    case (i_op)
      SHIFT_SLL: begin
        if (w_n <= 32'(W)) {o_carry, o_data} = w_sll;
        else               o_data = '0;
      end
      SHIFT_SRL: begin
        if (w_n <= 32'(W)) {o_data, o_carry} = w_srl;
        else               o_data = '0;
      end
      SHIFT_SRA: {o_data, o_carry} = w_sra;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SHIFT_ROTATE_EN
      SHIFT_ROL: begin
        o_data  = w_rol;
        o_carry = (w_n != 32'd0) ? w_rol[0] : 1'b0;
      end
      SHIFT_ROR: begin
        o_data  = w_ror;
        o_carry = (w_n != 32'd0) ? w_ror[W-1] : 1'b0;
      end
`endif
      default: begin
        o_data  = CLEAR_DATA;
        o_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_shift.sv
// ES1 SPU multi-mode shift unit: combinational core plus a LATENCY-deep
// clock-enabled clear/hold/valid pipeline. Rotates are available only when
// ELIXIRCHIP_ES1_SPU_OP_SHIFT_ROTATE_EN is defined.
module elixirchip_es1_spu_op_shift
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY         = 2,
  parameter int    DATA_BITS       = 32,
  parameter type   data_t          = logic [DATA_BITS-1:0],
  parameter int    MAX_SHIFT       = DATA_BITS,
  parameter int    SHIFT_BITS      = $clog2(MAX_SHIFT + 1),
  parameter data_t CLEAR_DATA      = '0,
  parameter bit    IMMEDIATE_SHIFT = 1'b0,
  parameter bit    IMMEDIATE_OP    = 1'b0,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cke,
  elixirchip_es1_spu_op_shift_if.slave s_bus
);
  typedef struct packed {
    data_t data;
    logic  carry;
    logic  valid;
  } stage_t;

  localparam stage_t STAGE_RST = '{data: CLEAR_DATA, carry: 1'b0, valid: 1'b0};

  data_t  w_res;
  logic   w_car;
  stage_t w_stg [1:LATENCY];

  elixirchip_es1_spu_op_shift_core #(
    .DATA_BITS  (DATA_BITS),
    .SHIFT_BITS (SHIFT_BITS),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_core (
    .i_op    (s_bus.s_op),
    .i_shift (s_bus.s_shift),
    .i_data  (s_bus.s_data),
    .o_data  (w_res),
    .o_carry (w_car)
  );

  for (genvar g = 1; g <= LATENCY; g++) begin : g_stage
    stage_t r_stg;
    if (g == 1) begin : g_first
      // Stage 1: clear beats over valid beats; idle cycles hold data and drop valid
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stg <= STAGE_RST;
        end else if (cke) begin
          if (s_bus.s_clear)      r_stg <= '{data: CLEAR_DATA, carry: 1'b0, valid: s_bus.s_valid};
          else if (s_bus.s_valid) r_stg <= '{data: w_res, carry: w_car, valid: 1'b1};
          else                    r_stg.valid <= 1'b0;
        end
      end
    end else begin : g_copy
      // Stages 2..LATENCY: plain delay of the previous stage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  r_stg <= STAGE_RST;
        else if (cke)  r_stg <= w_stg[g-1];
      end
    end
    assign w_stg[g] = r_stg;
  end

  assign s_bus.m_data  = w_stg[LATENCY].data;
  assign s_bus.m_carry = w_stg[LATENCY].carry;
  assign s_bus.m_valid = w_stg[LATENCY].valid;

  // Constant-operand and debug flags are folding hints only; the generic datapath covers them.
  if ((IMMEDIATE_SHIFT || IMMEDIATE_OP) && DEBUG == "true" && DEVICE != "RTL") begin : g_cfg_hint
  end

  if (SIMULATION == "true") begin : g_sim_chk
    logic w_op_legal;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SHIFT_ROTATE_EN
    assign w_op_legal = (s_bus.s_op <= SHIFT_ROR);
`else
    assign w_op_legal = (s_bus.s_op <= SHIFT_SRA);
`endif
    // Flag out-of-contract beats as they are accepted into stage 1
    always_ff @(posedge clk) begin
      if (reset_n && cke && s_bus.s_valid && !s_bus.s_clear) begin
        if (!w_op_legal)
          $error("%s shift: reserved s_op %0d", DEVICE, s_bus.s_op);
        if (32'(s_bus.s_shift) > 32'(MAX_SHIFT))
          $error("%s shift: s_shift %0d above MAX_SHIFT %0d", DEVICE, s_bus.s_shift, MAX_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_shift.sv
// Scoreboard bench for elixirchip_es1_spu_op_shift (DATA_BITS=32, MAX_SHIFT=32, LATENCY=3, CLEAR_DATA=123).
module tb_elixirchip_es1_spu_op_shift;
  localparam int          LAT = 3;
  localparam logic [31:0] CLR = 32'd123;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic        v;
    int          due;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic cke = 1'b0;

  int chk = 0;
  int fails = 0;
  int en_cnt = 0;
  ent_t q[$];
  logic [31:0] st_d = CLR;
  logic        st_c = 1'b0;
  logic [31:0] exp_d = CLR;
  logic        exp_c = 1'b0;
  logic        exp_v = 1'b0;

  elixirchip_es1_spu_op_shift_if #(.DATA_BITS(32), .SHIFT_BITS(6)) bus ();

  elixirchip_es1_spu_op_shift #(
    .LATENCY    (LAT),
    .DATA_BITS  (32),
    .MAX_SHIFT  (32),
    .CLEAR_DATA (CLR),
    .SIMULATION ("false")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .s_bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit rot_en();
`ifdef ELIXIRCHIP_ES1_SPU_OP_SHIFT_ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Bit-serial reference: shift one position at a time, carry = last bit that fell off.
  function automatic logic [32:0] model(logic [2:0] op, int n, logic [31:0] d);
    logic [31:0] r = d;
    logic        c = 1'b0;
    case (op)
      3'd0: for (int i = 0; i < n; i++) begin c = r[31]; r = {r[30:0], 1'b0}; end
      3'd1: for (int i = 0; i < n; i++) begin c = r[0];  r = {1'b0, r[31:1]}; end
      3'd2: for (int i = 0; i < n; i++) begin c = r[0];  r = {r[31], r[31:1]}; end
      3'd3, 3'd4: begin
        if (rot_en()) begin
          for (int i = 0; i < n % 32; i++) r = (op == 3'd3) ? {r[30:0], r[31]} : {r[0], r[31:1]};
          c = (n == 0) ? 1'b0 : ((op == 3'd3) ? r[0] : r[31]);
        end else begin
          r = CLR; c = 1'b0;
        end
      end
      default: begin r = CLR; c = 1'b0; end
    endcase
    return {c, r};
  endfunction

  task automatic drive(input logic [2:0] op, input int n, input logic [31:0] d,
                       input logic clr, input logic v);
    bus.s_op    = op;
    bus.s_shift = 6'(n);
    bus.s_data  = d;
    bus.s_clear = clr;
    bus.s_valid = v;
  endtask

  // Advance one clock; on enabled edges push the stage-1 expectation and retire due entries.
  task automatic tick();
    logic [32:0] r;
    ent_t e;
    @(posedge clk);
    if (cke && reset_n) begin
      if (bus.s_clear) begin
        st_d = CLR; st_c = 1'b0;
        q.push_back('{d: st_d, c: st_c, v: bus.s_valid, due: en_cnt + LAT});
      end else if (bus.s_valid) begin
        r = model(bus.s_op, int'(bus.s_shift), bus.s_data);
        st_d = r[31:0]; st_c = r[32];
        q.push_back('{d: st_d, c: st_c, v: 1'b1, due: en_cnt + LAT});
      end else begin
        q.push_back('{d: st_d, c: st_c, v: 1'b0, due: en_cnt + LAT});
      end
      en_cnt++;
      if (q.size() > 0 && q[0].due == en_cnt) begin
        e = q.pop_front();
        exp_d = e.d; exp_c = e.c; exp_v = e.v;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    st_d = CLR; st_c = 1'b0;
    exp_d = CLR; exp_c = 1'b0; exp_v = 1'b0;
  endtask

  task automatic test_reset();
    drive(3'd0, 0, 32'h0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk++;
    if ({bus.m_valid, bus.m_carry, bus.m_data} !== {1'b0, 1'b0, CLR}) begin
      fails++;
      $display("FAIL reset_async got v=%b c=%b d=%h want v=0 c=0 d=%h", bus.m_valid, bus.m_carry, bus.m_data, CLR);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cke = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk++;
      if ({bus.m_valid, bus.m_carry, bus.m_data} !== {exp_v, exp_c, exp_d}) begin
        fails++;
        $display("FAIL reset_idle got v=%b c=%b d=%h want v=%b c=%b d=%h", bus.m_valid, bus.m_carry, bus.m_data, exp_v, exp_c, exp_d);
      end
    end
  endtask

  task automatic test_vectors();
    localparam int N = 13;
    logic [2:0]  tv_op [N];
    int          tv_n  [N];
    logic [31:0] tv_in [N];
    logic [31:0] tv_d  [N];
    logic        tv_c  [N];
    int k = 0;
    tv_op = '{3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0, 3'd1, 3'd1, 3'd6, 3'd2, 3'd0};
    tv_n  = '{8, 8, 4, 8, 36, 32, 0, 32, 32, 33, 5, 31, 31};
    tv_in = '{32'h87654321, 32'h87654321, 32'h12345678, 32'h12345678, 32'h12345678,
              32'h87654321, 32'h12345678, 32'h00000001, 32'h80000000, 32'hffffffff,
              32'h12345678, 32'h80000000, 32'h00000003};
    tv_d  = '{32'hff876543, 32'h00876543, 32'h23456780, 32'h78123456, 32'h23456781,
              32'hffffffff, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000,
              CLR, 32'hffffffff, 32'h80000000};
    tv_c  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    if (!rot_en()) begin
      tv_d[3] = CLR; tv_c[3] = 1'b0;
      tv_d[4] = CLR; tv_c[4] = 1'b0;
    end
    for (int i = 0; i < N + LAT + 2; i++) begin
      if (i < N) drive(tv_op[i], tv_n[i], tv_in[i], 1'b0, 1'b1);
      else       drive(3'd0, 0, 32'h0, 1'b0, 1'b0);
      tick();
      chk++;
      if ({bus.m_valid, bus.m_carry, bus.m_data} !== {exp_v, exp_c, exp_d}) begin
        fails++;
        $display("FAIL vectors_sb cyc=%0d got v=%b c=%b d=%h want v=%b c=%b d=%h", i, bus.m_valid, bus.m_carry, bus.m_data, exp_v, exp_c, exp_d);
      end
      if (bus.m_valid) begin
        chk++;
        if (k >= N || bus.m_data !== tv_d[k] || bus.m_carry !== tv_c[k]) begin
          fails++;
          $display("FAIL vector%0d got c=%b d=%h want c=%b d=%h", k, bus.m_carry, bus.m_data, tv_c[k], tv_d[k]);
        end
        k++;
      end
    end
    chk++;
    if (k != N) begin
      fails++;
      $display("FAIL vectors_count got %0d want %0d", k, N);
    end
  endtask

  task automatic test_cke_clear();
    int nv = 0;
    for (int i = 0; i < 7 + LAT + 1; i++) begin
      cke = 1'b1;
      case (i)
        0: drive(3'd1, 4, 32'hf0f0f0f0, 1'b0, 1'b1);
        1: drive(3'd0, 1, 32'h80000001, 1'b0, 1'b1);
        2: begin cke = 1'b0; drive(3'd0, 1, 32'hdeadbeef, 1'b1, 1'b1); end
        3: begin cke = 1'b0; drive(3'd2, 3, 32'hcafef00d, 1'b0, 1'b1); end
        4: drive(3'd2, 30, 32'h40000000, 1'b0, 1'b1);
        5: drive(3'd0, 3, 32'h11111111, 1'b1, 1'b1);
        default: drive(3'd0, 0, 32'h0, 1'b0, 1'b0);
      endcase
      tick();
      chk++;
      if ({bus.m_valid, bus.m_carry, bus.m_data} !== {exp_v, exp_c, exp_d}) begin
        fails++;
        $display("FAIL cke_clear cyc=%0d got v=%b c=%b d=%h want v=%b c=%b d=%h", i, bus.m_valid, bus.m_carry, bus.m_data, exp_v, exp_c, exp_d);
      end
      if (bus.m_valid) nv++;
    end
    chk++;
    if (nv != 4) begin
      fails++;
      $display("FAIL cke_beats got %0d want 4", nv);
    end
    chk++;
    if (bus.m_data !== CLR || bus.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_hold got v=%b d=%h want v=0 d=%h", bus.m_valid, bus.m_data, CLR);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    cke = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, i + 1, 32'h89abcdef, 1'b0, 1'b1);
      tick();
    end
    drive(3'd0, 0, 32'h0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk++;
    if ({bus.m_valid, bus.m_carry, bus.m_data} !== {1'b0, 1'b0, CLR}) begin
      fails++;
      $display("FAIL reset_mid got v=%b c=%b d=%h want v=0 c=0 d=%h", bus.m_valid, bus.m_carry, bus.m_data, CLR);
    end
    model_reset();
    #1 reset_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      chk++;
      if ({bus.m_valid, bus.m_carry, bus.m_data} !== {1'b0, 1'b0, CLR}) begin
        fails++;
        $display("FAIL reset_stale cyc=%0d got v=%b c=%b d=%h want v=0 c=0 d=%h", i, bus.m_valid, bus.m_carry, bus.m_data, CLR);
      end
    end
    drive(3'd6, 4, 32'h55aa55aa, 1'b0, 1'b1);
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      drive(3'd0, 0, 32'h0, 1'b0, 1'b0);
      chk++;
      if ({bus.m_valid, bus.m_carry, bus.m_data} !== {exp_v, exp_c, exp_d}) begin
        fails++;
        $display("FAIL reserved_sb cyc=%0d got v=%b c=%b d=%h want v=%b c=%b d=%h", i, bus.m_valid, bus.m_carry, bus.m_data, exp_v, exp_c, exp_d);
      end
      if (bus.m_valid) begin
        nv++;
        chk++;
        if (bus.m_data !== CLR || bus.m_carry !== 1'b0) begin
          fails++;
          $display("FAIL reserved_op got c=%b d=%h want c=0 d=%h", bus.m_carry, bus.m_data, CLR);
        end
      end
    end
    chk++;
    if (nv != 1) begin
      fails++;
      $display("FAIL reserved_count got %0d want 1", nv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80 + LAT + 1; i++) begin
      if (i < 80) begin
        cke = ($urandom_range(0, 3) != 0);
        drive(3'($urandom_range(0, 7)), $urandom_range(0, 32), $urandom,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      end else begin
        cke = 1'b1;
        drive(3'd0, 0, 32'h0, 1'b0, 1'b0);
      end
      tick();
      chk++;
      if ({bus.m_valid, bus.m_carry, bus.m_data} !== {exp_v, exp_c, exp_d}) begin
        fails++;
        $display("FAIL random cyc=%0d got v=%b c=%b d=%h want v=%b c=%b d=%h", i, bus.m_valid, bus.m_carry, bus.m_data, exp_v, exp_c, exp_d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_cke_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
